// File: rtl/shift_window_ctrl.sv
// Sequencer for a DEPTH-stage word shift chain: shift enable/clear, tap count and window handshake.
// Optional partial-window timeout is built when SHIFT_CTRL_TIMEOUT_EN is defined.
module shift_window_ctrl #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_mode,
    input  logic                             i_flush,
    input  logic                             i_in_valid,
    output logic                             o_in_ready,
    input  logic [WIDTH-1:0]                 i_in_data,
    output logic                             o_shift_en,
    output logic [WIDTH-1:0]                 o_shift_data,
    output logic                             o_chain_clr,
    output logic                             o_win_valid,
    input  logic                             i_win_ready,
    output logic [$clog2(DEPTH+1)-1:0]       o_win_count,
    output logic                             o_win_partial,
    output logic                             o_busy
);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             partial;
    logic             accept, consume;

`ifdef SHIFT_CTRL_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT+1);
    logic [TMR_W-1:0] timer, timer_nxt;
    logic             partial_nxt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            timer   <= '0;
            partial <= 1'b0;
        end else begin
            timer   <= timer_nxt;
            partial <= partial_nxt;
        end
    end
`else
    assign partial = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
`ifdef SHIFT_CTRL_TIMEOUT_EN
        partial_nxt = partial;
        timer_nxt   = '0;
`endif
        if (i_flush) begin
            state_nxt = IDLE;
            count_nxt = '0;
`ifdef SHIFT_CTRL_TIMEOUT_EN
            partial_nxt = 1'b0;
`endif
        end else if (consume && (!i_mode || partial)) begin
            state_nxt = IDLE;
            count_nxt = '0;
`ifdef SHIFT_CTRL_TIMEOUT_EN
            partial_nxt = 1'b0;
`endif
        end else if (consume) begin
            // sliding: oldest word drops out, an accepted word refills the window
            count_nxt = CNT_W'(DEPTH-1) + CNT_W'(accept);
            state_nxt = accept ? FULL : FILL;
        end else if (accept) begin
            count_nxt = count + 1'b1;
            state_nxt = (count + 1'b1 == CNT_W'(DEPTH)) ? FULL : FILL;
`ifdef SHIFT_CTRL_TIMEOUT_EN
        end else if (state == FILL) begin
            if (timer == TMR_W'(TIMEOUT-1)) begin
                state_nxt   = FULL;
                partial_nxt = 1'b1;
            end else begin
                timer_nxt = timer + 1'b1;
            end
`endif
        end
    end

    always_comb begin
        o_win_valid   = (state == FULL) && !i_flush;
        o_in_ready    = !i_reset && !i_flush &&
                        ((state != FULL) || (i_mode && i_win_ready && !partial));
        accept        = i_in_valid && o_in_ready;
        consume       = o_win_valid && i_win_ready;
        o_shift_en    = accept;
        o_shift_data  = i_in_data;
        o_chain_clr   = i_flush && !i_reset;
        o_win_count   = count;
        o_win_partial = partial;
        o_busy        = (state != IDLE);
    end
endmodule

// File: tb/tb_shift_window_ctrl.sv
// Bench for shift_window_ctrl: queue-based window model checked every cycle plus directed literal checks.
module tb_shift_window_ctrl;
    localparam int WIDTH   = 32;
    localparam int DEPTH   = 3;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = $clog2(DEPTH+1);

    logic             clk = 0;
    logic             i_reset, i_mode, i_flush, i_in_valid, i_win_ready;
    logic [WIDTH-1:0] i_in_data;
    logic             o_in_ready, o_shift_en, o_chain_clr, o_win_valid, o_win_partial, o_busy;
    logic [WIDTH-1:0] o_shift_data;
    logic [CNT_W-1:0] o_win_count;

    int total = 0;
    int bad   = 0;

    // model: the window is the list of captured words; pres = window presented
    logic [WIDTH-1:0] q[$];
    bit pres, part;
    int idle;

    shift_window_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_mode(i_mode), .i_flush(i_flush),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
        .o_shift_en(o_shift_en), .o_shift_data(o_shift_data), .o_chain_clr(o_chain_clr),
        .o_win_valid(o_win_valid), .i_win_ready(i_win_ready), .o_win_count(o_win_count),
        .o_win_partial(o_win_partial), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        bit e_wv, e_rdy, acc, cons;
        if (i_reset) begin
            q.delete(); pres = 0; part = 0; idle = 0;
        end else begin
            e_wv  = pres && !i_flush;
            e_rdy = !i_flush && (!pres || (i_mode && i_win_ready && !part));
            acc   = i_in_valid && e_rdy;
            cons  = e_wv && i_win_ready;
            chk("m_win_valid", int'(o_win_valid), int'(e_wv));
            chk("m_in_ready",  int'(o_in_ready),  int'(e_rdy));
            chk("m_shift_en",  int'(o_shift_en),  int'(acc));
            chk("m_chain_clr", int'(o_chain_clr), int'(i_flush));
            chk("m_win_count", int'(o_win_count), q.size());
            chk("m_partial",   int'(o_win_partial), int'(part));
            chk("m_busy",      int'(o_busy), int'(q.size() != 0));
            if (acc) chk("m_shift_data", int'(o_shift_data), int'(i_in_data));
            if (i_flush || (cons && (!i_mode || part))) begin
                q.delete(); pres = 0; part = 0; idle = 0;
            end else if (cons) begin
                void'(q.pop_front());
                if (acc) q.push_back(i_in_data);
                pres = acc; idle = 0;
            end else if (acc) begin
                q.push_back(i_in_data);
                pres = (q.size() == DEPTH); idle = 0;
            end else if (!pres && q.size() > 0) begin
                idle++;
`ifdef SHIFT_CTRL_TIMEOUT_EN
                if (idle == TIMEOUT) begin pres = 1; part = 1; idle = 0; end
`endif
            end else begin
                idle = 0;
            end
        end
    end

    initial begin
        i_reset = 1; i_mode = 0; i_flush = 0; i_in_valid = 0; i_win_ready = 0; i_in_data = '0;
        repeat (2) cycle();
        i_reset = 0;
        @(negedge clk);
        chk("rst_count", int'(o_win_count), 0);
        chk("rst_busy",  int'(o_busy), 0);
        chk("rst_wv",    int'(o_win_valid), 0);

        // reset mid-fill
        cycle();
        i_in_valid = 1; i_in_data = 32'h11; cycle();
        i_in_data = 32'h22; cycle();
        i_in_valid = 1; i_in_data = 32'h33;
        @(negedge clk);
        chk("t1_count2", int'(o_win_count), 2);
        #2 i_reset = 1;
        #1;
        chk("t1_async_wv",  int'(o_win_valid), 0);
        chk("t1_async_rdy", int'(o_in_ready), 0);
        chk("t1_async_sh",  int'(o_shift_en), 0);
        chk("t1_async_clr", int'(o_chain_clr), 0);
        chk("t1_async_cnt", int'(o_win_count), 0);
        i_in_valid = 0;
        repeat (2) cycle();
        i_reset = 0;
        @(negedge clk);
        chk("t1_cnt_after", int'(o_win_count), 0);
        chk("t1_busy_after", int'(o_busy), 0);

        // block mode A,B,C
        cycle();
        i_mode = 0; i_in_valid = 1;
        for (int k = 0; k < 3; k++) begin
            i_in_data = 32'hA0 + k;
            @(negedge clk);
            chk("t2_shift_en", int'(o_shift_en), 1);
            cycle();
        end
        i_in_valid = 0;
        @(negedge clk);
        chk("t2_wv", int'(o_win_valid), 1);
        chk("t2_cnt", int'(o_win_count), 3);
        chk("t2_rdy", int'(o_in_ready), 0);
        // full, source pushing, consumer stalled
        i_in_valid = 1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            @(negedge clk);
            chk("t5_rdy", int'(o_in_ready), 0);
            chk("t5_sh", int'(o_shift_en), 0);
        end
        cycle();
        i_in_valid = 0; i_win_ready = 1;
        cycle();
        i_win_ready = 0;
        @(negedge clk);
        chk("t2_cnt0", int'(o_win_count), 0);
        chk("t2_idle", int'(o_busy), 0);

        // sliding mode
        cycle();
        i_mode = 1; i_in_valid = 1;
        for (int k = 0; k < 3; k++) begin i_in_data = 32'hB0 + k; cycle(); end
        i_win_ready = 1;
        for (int k = 0; k < 2; k++) begin
            i_in_data = 32'hD0 + k;
            @(negedge clk);
            chk("t3_sh", int'(o_shift_en), 1);
            chk("t3_wv", int'(o_win_valid), 1);
            chk("t3_cnt", int'(o_win_count), 3);
            cycle();
        end
        i_in_valid = 0;
        cycle();
        i_win_ready = 0;
        @(negedge clk);
        chk("t3_cnt2", int'(o_win_count), 2);
        chk("t3_wv0", int'(o_win_valid), 0);
        chk("t3_busy", int'(o_busy), 1);
        i_in_valid = 1; i_in_data = 32'hF0; cycle();
        i_in_valid = 0;

        // flush beats consume
        i_flush = 1; i_win_ready = 1;
        @(negedge clk);
        chk("t4_wv", int'(o_win_valid), 0);
        chk("t4_clr", int'(o_chain_clr), 1);
        cycle();
        i_flush = 0; i_win_ready = 0;
        @(negedge clk);
        chk("t4_cnt", int'(o_win_count), 0);
        chk("t4_busy", int'(o_busy), 0);

`ifdef SHIFT_CTRL_TIMEOUT_EN
        cycle();
        i_mode = 0; i_in_valid = 1; i_in_data = 32'h61; cycle();
        i_in_data = 32'h62; cycle();
        i_in_valid = 0;
        repeat (TIMEOUT) cycle();
        i_mode = 1; i_win_ready = 1;
        @(negedge clk);
        chk("t6_wv", int'(o_win_valid), 1);
        chk("t6_part", int'(o_win_partial), 1);
        chk("t6_cnt", int'(o_win_count), 2);
        chk("t6_rdy", int'(o_in_ready), 0);
        cycle();
        i_win_ready = 0;
        @(negedge clk);
        chk("t6_cnt0", int'(o_win_count), 0);
        chk("t6_part0", int'(o_win_partial), 0);
        chk("t6_busy", int'(o_busy), 0);
`endif

        // random traffic; second half starves the source to exercise timeouts
        for (int n = 0; n < 3000; n++) begin
            cycle();
            if ($urandom_range(15) == 0) i_mode = ~i_mode;
            i_flush     = ($urandom_range(40) == 0);
            i_in_valid  = (n < 1500) ? ($urandom_range(3) != 0) : ($urandom_range(2) == 0);
            i_win_ready = ($urandom_range(2) != 0);
            i_in_data   = $urandom;
            if (n == 2000) begin
                i_reset = 1; cycle(); cycle(); i_reset = 0;
            end
        end
        cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
